// File: rtl/priority_encoder_32to5.sv
// Purpose: captures a 32-bit request vector and emits the set-bit indices one per handshake, lowest index first.
// Latency: 1 cycle from accepted load to the first presented index; done pulses 1 cycle after the last accept.
// Backpressure: out_index/remaining hold while out_ready=0; load_ready=0 while a vector is draining.
module priority_encoder_32to5 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [31:0] req_in,
  input  logic        flush,
  input  logic        out_ready,
  output logic        load_ready,
  output logic        out_valid,
  output logic [4:0]  out_index,
  output logic [5:0]  remaining,
  output logic        done
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pending;
  logic [31:0] w_pending_nxt;
  logic [4:0]  r_index;
  logic [4:0]  w_index_nxt;
  logic [5:0]  r_remaining;
  logic [5:0]  w_remaining_nxt;
  logic        r_done;
  logic        w_done_nxt;
  logic [31:0] w_drop_pending;

  // Index of the lowest set bit; 0 for an all-zero vector.
  function automatic logic [4:0] f_lowest(input logic [31:0] v);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) idx = i[4:0];
    end
    return idx;
  endfunction

  // Number of set bits, 0..32.
  function automatic logic [5:0] f_popcount(input logic [31:0] v);
    logic [5:0] cnt;
    cnt = 6'd0;
    for (int i = 0; i < 32; i++) begin
      cnt = cnt + {5'd0, v[i]};
    end
    return cnt;
  endfunction

  // Pending set with the currently presented bit removed.
  assign w_drop_pending = r_pending & ~(32'd1 << r_index);

  // State and datapath registers; reset forces IDLE with everything cleared.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_pending   <= 32'd0;
      r_index     <= 5'd0;
      r_remaining <= 6'd0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pending   <= w_pending_nxt;
      r_index     <= w_index_nxt;
      r_remaining <= w_remaining_nxt;
      r_done      <= w_done_nxt;
    end
  end

  // Next-state logic; flush overrides both load and a same-cycle handshake.
  always_comb begin
    w_state_nxt     = r_state;
    w_pending_nxt   = r_pending;
    w_index_nxt     = r_index;
    w_remaining_nxt = r_remaining;
    w_done_nxt      = 1'b0;
    if (flush) begin
      w_state_nxt     = S_IDLE;
      w_pending_nxt   = 32'd0;
      w_index_nxt     = 5'd0;
      w_remaining_nxt = 6'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (load) begin
            if (req_in != 32'd0) begin
              w_state_nxt     = S_EMIT;
              w_pending_nxt   = req_in;
              w_index_nxt     = f_lowest(req_in);
              w_remaining_nxt = f_popcount(req_in);
            end else begin
              // Empty vector drains immediately.
              w_done_nxt = 1'b1;
            end
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            if (w_drop_pending != 32'd0) begin
              w_pending_nxt   = w_drop_pending;
              w_index_nxt     = f_lowest(w_drop_pending);
              w_remaining_nxt = r_remaining - 6'd1;
            end else begin
              w_state_nxt     = S_IDLE;
              w_pending_nxt   = 32'd0;
              w_index_nxt     = 5'd0;
              w_remaining_nxt = 6'd0;
              w_done_nxt      = 1'b1;
            end
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Outputs come straight from registers only.
  always_comb begin
    load_ready = (r_state == S_IDLE);
    out_valid  = (r_state == S_EMIT);
    out_index  = r_index;
    remaining  = r_remaining;
    done       = r_done;
  end

endmodule

// File: doc/priority_encoder_32to5.md
PRIORITY_ENCODER_32TO5 -- requirements
Module: priority_encoder_32to5

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 load  input  1  request to capture req_in; accepted only when load_ready=1.
REQ-005 req_in  input  32  one-hot-or-multi-hot request vector; bit i requests index i.
REQ-006 flush  input  1  abort current scan; discard all pending bits.
REQ-007 out_ready  input  1  consumer accepts out_index this cycle.
REQ-008 load_ready  output  1  block idle, can accept a load.
REQ-009 out_valid  output  1  out_index holds a valid encoded index.
REQ-010 out_index  output  5  binary index of lowest pending set bit.
REQ-011 remaining  output  6  number of pending bits not yet accepted, including the presented one; range 0..32.
REQ-012 done  output  1  one-cycle pulse when a loaded vector is fully drained.

Function
REQ-013 The state machine SHALL have two states: IDLE and EMIT.
REQ-014 IDLE: load_ready=1, out_valid=0.
REQ-015 In IDLE, load=1 with req_in!=0 SHALL capture req_in into the pending register and enter EMIT.
REQ-016 In that case, the next cycle SHALL show out_valid=1, out_index=lowest set bit of req_in, remaining=popcount(req_in). Latency is 1 cycle.
REQ-017 In IDLE, load=1 with req_in==0 SHALL stay in IDLE and pulse done=1 on the next cycle.
REQ-018 In EMIT: load_ready=0; load is ignored and does not change pending.
REQ-019 In EMIT, out_valid=1. out_index and remaining SHALL hold stable while out_ready=0.
REQ-020 Handshake in EMIT: when out_valid=1 and out_ready=1, the presented bit SHALL clear from pending.
  - remaining SHALL decrement by 1.
  - If bits remain: the next cycle presents the next lowest set bit, with no bubble cycle.
  - If none remain: the next cycle enters IDLE with done=1 for exactly one cycle.
REQ-021 Priority is fixed lowest-index-first. Bit 0 is the highest priority; bit 31 is the lowest.
REQ-022 out_index SHALL be registered. No combinational path from req_in or out_ready to out_index.
REQ-023 When out_valid=0, out_index SHALL be 0 and remaining SHALL be 0.
REQ-024 flush=1 in any state SHALL, on the next edge:
  - clear pending;
  - enter IDLE with out_valid=0 and no done pulse.
REQ-025 flush SHALL take priority over load and over a simultaneous handshake.
REQ-026 req_in=32'hFFFF_FFFF SHALL produce indices 0..31 in order, remaining 32 down to 1, then done.
REQ-027 load=1 in IDLE on the same cycle done is asserted SHALL be accepted normally, allowing back-to-back vectors.

Reset
REQ-028 reset_n=0 SHALL immediately, without waiting for clk:
  - force IDLE and pending=0;
  - set load_ready=1, out_valid=0, out_index=0, remaining=0, done=0.
REQ-029 Reset asserted mid-EMIT SHALL discard all pending bits. After release, the first load behaves as from power-up.

Verification
REQ-030 Load 32'h0000_0001, out_ready=1 -> next cycle out_index=0, remaining=1; following cycle done=1, load_ready=1.
REQ-031 Load 32'h8000_0104, out_ready=1 -> indices 2, 8, 31 on consecutive cycles, remaining 3, 2, 1, then done pulse.
REQ-032 Load 32'h0000_0030, out_ready=0 for 3 cycles -> out_index=4 held stable; then out_ready=1 -> 4, 5, done.
REQ-033 Load 32'h0 -> done=1 next cycle, out_valid never asserted.
REQ-034 Load 32'hFFFF_FFFF, flush after 3 accepts -> IDLE next cycle, out_valid=0, no done.
REQ-035 Load 32'hFFFF_FFFF, drive reset_n=0 mid-drain -> outputs reset asynchronously. After release, load 32'h2 -> out_index=1.
REQ-036 Load 32'hF000_0000, and load 32'h1 while in EMIT -> the second load is ignored; only 28..31 are emitted.
